// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: next-PC select codes and flush/halt FSM state encodings shared by pc_sequencer and pc_flush_ctrl
package pc_sequencer_pkg;
  localparam logic [1:0] PCSEL_TARGET = 2'b00;
  localparam logic [1:0] PCSEL_JALR = 2'b01;
  localparam logic [1:0] PCSEL_PC4 = 2'b10;
  localparam logic [1:0] PCSEL_HALT = 2'b11;
  typedef enum logic [1:0] {
    PCS_RUN = 2'b00,
    PCS_FLUSH = 2'b01,
    PCS_HALTED = 2'b10
  } pcs_state_t;
endpackage

// File: rtl/pc_flush_ctrl.sv
// pc_flush_ctrl: RUN/FLUSH/HALTED FSM with flush counter; in clk rst redirect halt, out state flush (registered, FLUSH_CYCLES long after redirect, 1 cycle on halt entry) halted
module pc_flush_ctrl import pc_sequencer_pkg::*; #(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       redirect,
  input  logic       halt,
  output pcs_state_t state,
  output logic       flush,
  output logic       halted
);
  localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);
  pcs_state_t state_d;
  logic [1:0] cnt, cnt_d;
  logic flush_d;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    flush_d = 1'b0;
    state_d = state == PCS_RUN ? (halt ? PCS_HALTED : redirect ? PCS_FLUSH : PCS_RUN)
            : state == PCS_FLUSH ? (cnt == 2'd0 ? PCS_RUN : PCS_FLUSH)
            : PCS_HALTED;
    cnt_d = state == PCS_RUN ? CNT_INIT : cnt - 2'd1;
    flush_d = state_d == PCS_FLUSH | (state == PCS_RUN & halt);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PCS_RUN;
      cnt <= 2'd0;
      flush <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      flush <= flush_d;
    end
  end
  assign halted = state == PCS_HALTED;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register, PC+4 adder and branch/JALR target mux with flush/halt control; in clk rst pc_sel sel_valid branch_target jalr_target stall, out pc pc_plus4 fetch_valid flush_if_id flush_id_ex halted [misalign when PC_ALIGN_CHECK_EN]
module pc_sequencer import pc_sequencer_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_sel,
  input  logic        sel_valid,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush_if_id,
  output logic        flush_id_ex,
`ifdef PC_ALIGN_CHECK_EN
  output logic        misalign,
`endif
  output logic        halted
);
  pcs_state_t state;
  logic [31:0] target, pc_next;
  logic is_redir, is_halt, bad, run, redirect, halt, flush;
  assign pc_plus4 = pc + 32'd4;
  always_comb begin
    target = pc_sel == PCSEL_JALR ? jalr_target & ~32'd1 : branch_target;
    is_redir = sel_valid & (pc_sel == PCSEL_TARGET | pc_sel == PCSEL_JALR);
    is_halt = sel_valid & pc_sel == PCSEL_HALT;
`ifdef PC_ALIGN_CHECK_EN
    bad = is_redir & |target[1:0];
`else
    bad = 1'b0;
`endif
    run = state == PCS_RUN;
    redirect = run & is_redir & ~bad;
    halt = run & (is_halt | (is_redir & bad));
    pc_next = state == PCS_FLUSH ? pc_plus4
            : redirect ? target
            : (~run | halt | stall) ? pc
            : pc_plus4;
  end
  always_ff @(posedge clk) begin
    pc <= rst ? RESET_PC : pc_next;
  end
`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    misalign <= rst ? 1'b0 : misalign | (run & is_redir & bad);
  end
`endif
  pc_flush_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_ctrl (
    .clk(clk),
    .rst(rst),
    .redirect(redirect),
    .halt(halt),
    .state(state),
    .flush(flush),
    .halted(halted)
  );
  assign flush_if_id = flush;
  assign flush_id_ex = flush;
  assign fetch_valid = ~rst & ~halted;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer driven from a cycle model
module tb_pc_sequencer;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int FC = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel_valid = 1'b0;
  logic stall = 1'b0;
  logic [1:0] pc_sel = 2'b10;
  logic [31:0] branch_target = '0;
  logic [31:0] jalr_target = '0;
  logic [31:0] pc, pc_plus4;
  logic fetch_valid, flush_if_id, flush_id_ex, halted;
`ifdef PC_ALIGN_CHECK_EN
  logic misalign;
`endif
  always #5 clk = ~clk;
  pc_sequencer #(.RESET_PC(RST_PC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk),
    .rst(rst),
    .pc_sel(pc_sel),
    .sel_valid(sel_valid),
    .branch_target(branch_target),
    .jalr_target(jalr_target),
    .stall(stall),
    .pc(pc),
    .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid),
    .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex),
`ifdef PC_ALIGN_CHECK_EN
    .misalign(misalign),
`endif
    .halted(halted)
  );
  typedef struct packed {
    logic [31:0] pc;
    logic fv;
    logic fl;
    logic hl;
    logic mis;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] m_pc = RST_PC;
  int m_mode = 0;
  int m_left = 0;
  logic m_fl = 1'b0;
  logic m_mis = 1'b0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic r, input logic v, input logic [1:0] s, input logic [31:0] bt,
                     input logic [31:0] jt, input logic st);
    exp_t e;
    logic [31:0] t;
    logic bad;
    @(negedge clk);
    rst = r;
    sel_valid = v;
    pc_sel = s;
    branch_target = bt;
    jalr_target = jt;
    stall = st;
    t = s == 2'b01 ? {jt[31:1], 1'b0} : bt;
`ifdef PC_ALIGN_CHECK_EN
    bad = t[1:0] != 2'b00;
`else
    bad = 1'b0;
`endif
    if (r) begin
      m_pc = RST_PC; m_mode = 0; m_left = 0; m_fl = 1'b0; m_mis = 1'b0;
    end else if (m_mode == 2) m_fl = 1'b0;
    else if (m_mode == 1) begin
      m_pc += 32'd4; m_left--; m_fl = m_left > 0;
      if (m_left == 0) m_mode = 0;
    end else if (v && s == 2'b11) begin
      m_mode = 2; m_fl = 1'b1;
    end else if (v && !s[1] && bad) begin
      m_mode = 2; m_fl = 1'b1; m_mis = 1'b1;
    end else if (v && !s[1]) begin
      m_pc = t; m_left = FC; m_mode = 1; m_fl = 1'b1;
    end else begin
      m_fl = 1'b0;
      if (!st) m_pc += 32'd4;
    end
    e.pc = m_pc;
    e.fv = !r && m_mode != 2;
    e.fl = m_fl;
    e.hl = m_mode == 2;
    e.mis = m_mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("pc", pc, e.pc);
    check("pc_plus4", pc_plus4, e.pc + 32'd4);
    check("fetch_valid", 32'(fetch_valid), 32'(e.fv));
    check("flush_if_id", 32'(flush_if_id), 32'(e.fl));
    check("flush_id_ex", 32'(flush_id_ex), 32'(e.fl));
    check("halted", 32'(halted), 32'(e.hl));
`ifdef PC_ALIGN_CHECK_EN
    check("misalign", 32'(misalign), 32'(e.mis));
`endif
  endtask
  task automatic step(input logic st);
    cyc(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, st);
  endtask
  task automatic redir(input logic [1:0] s, input logic [31:0] bt, input logic [31:0] jt, input logic st);
    cyc(1'b0, 1'b1, s, bt, jt, st);
  endtask
  task automatic do_reset();
    cyc(1'b1, 1'b0, 2'b10, 32'h0, 32'h0, 1'b0);
  endtask
  initial begin
    repeat (2) do_reset();
    repeat (4) step(1'b0);
    redir(2'b00, 32'h40, 32'h0, 1'b0);
    repeat (FC + 2) step(1'b0);
    redir(2'b01, 32'h0, 32'h81, 1'b1);
    repeat (FC + 1) step(1'b0);
    redir(2'b00, 32'h20 - 32'(4 * FC), 32'h0, 1'b0);
    repeat (FC) step(1'b0);
    repeat (3) step(1'b1);
    step(1'b0);
    cyc(1'b0, 1'b1, 2'b10, 32'h0, 32'h0, 1'b0);
    redir(2'b01, 32'h0, 32'hFFFF_FFF1, 1'b0);
    repeat (FC + 4) step(1'b0);
    repeat (40) begin
      if (m_mode == 0 && $urandom_range(5) == 0)
        redir($urandom_range(1) == 1 ? 2'b01 : 2'b00, $urandom & ~32'd3, $urandom & ~32'd2,
              1'($urandom_range(1)));
      else if (m_mode == 0 && $urandom_range(5) == 0)
        cyc(1'b0, 1'b1, 2'b10, $urandom, $urandom, 1'($urandom_range(1)));
      else
        step(1'($urandom_range(1)));
    end
`ifdef PC_ALIGN_CHECK_EN
    redir(2'b00, 32'h42, 32'h0, 1'b0);
    repeat (3) step(1'b0);
    do_reset();
    step(1'b0);
`endif
    redir(2'b11, 32'h0, 32'h0, 1'b0);
    repeat (20) step(1'b0);
    redir(2'b00, 32'h100, 32'h0, 1'b0);
    do_reset();
    repeat (2) step(1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
